bist_response_checker: RTL

//   BIST session controller and response checker; the consuming end of the MISR signature path.

---
 rtl/bist_pkg.sv | 20 ++
 rtl/bist_sat_counter.sv | 38 +++
 rtl/bist_response_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types for the BIST response checker: FSM state encoding, default
// signature width and the sticky verdict bundle.
package bist_pkg;

    localparam int SIG_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_CMP  = 2'd3
    } bist_state_e;

    typedef struct packed {
        logic pass;
        logic fail;
        logic timeout;
    } verdict_t;

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with synchronous clear; counts RUN cycles for the
// response checker and flags when it has pinned at its maximum value.
module bist_sat_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign sat   = &count_q;
    assign count = count_q;

    // Clear has priority so a new session always starts counting from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !sat) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bist_response_checker.sv
// BIST session controller: resets and runs the core, captures its signature and
// posts a pass/fail verdict. Define BIST_CHK_TIMEOUT_EN to enable the RUN timeout.
module bist_response_checker
    import bist_pkg::*;
#(
    parameter int SIG_W       = SIG_W_DEFAULT,
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic             bist_ready,
    input  logic [SIG_W-1:0] bist_sig,
    output logic             bist_rst_n,
    output logic             bist_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [SIG_W-1:0] captured_sig,
    output logic [CNT_W-1:0] run_cycles,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CLR  = ST_CLR;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_CMP  = ST_CMP;

`ifdef BIST_CHK_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif
    // The limit fires in the last allowed RUN cycle, so the counter lands on TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic [SIG_W-1:0] captured_q, captured_d;
    verdict_t         verdict_q, verdict_d;
    logic             done_q, done_d;
    logic             bist_rst_n_q, bist_rst_n_d;
    logic             bist_valid_q, bist_valid_d;
    logic             busy_q, busy_d;
    logic             cnt_clear, cnt_enable, cnt_sat;
    logic             timeout_fire;

    bist_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (run_cycles),
        .sat    (cnt_sat)
    );

    assign timeout_fire = TIMEOUT_ON && (run_cycles == TIMEOUT_LAST);

    always_comb begin
        state_d    = state_q;
        golden_d   = golden_q;
        captured_d = captured_q;
        verdict_d  = verdict_q;
        done_d     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    golden_d  = golden_sig;
                    verdict_d = '0;
                    cnt_clear = 1'b1;
                    state_d   = S_CLR;
                end
            end
            S_CLR: begin
                if (abort) begin
                    verdict_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    verdict_d = '0;
                    state_d   = S_IDLE;
                end else if (bist_ready) begin
                    captured_d = bist_sig;
                    state_d    = S_CMP;
                end else begin
                    cnt_enable = !cnt_sat;
                    if (timeout_fire) begin
                        verdict_d.pass    = 1'b0;
                        verdict_d.fail    = 1'b1;
                        verdict_d.timeout = 1'b1;
                        done_d            = 1'b1;
                        state_d           = S_IDLE;
                    end
                end
            end
            S_CMP: begin
                if (abort) begin
                    verdict_d = '0;
                end else begin
                    verdict_d.pass    = (captured_q == golden_q);
                    verdict_d.fail    = (captured_q != golden_q);
                    verdict_d.timeout = 1'b0;
                    done_d            = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Core-facing outputs are registered from the next state so they align with it.
        bist_rst_n_d = (state_d != S_CLR);
        bist_valid_d = (state_d == S_RUN);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            golden_q     <= '0;
            captured_q   <= '0;
            verdict_q    <= '0;
            done_q       <= 1'b0;
            bist_rst_n_q <= 1'b1;
            bist_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            golden_q     <= golden_d;
            captured_q   <= captured_d;
            verdict_q    <= verdict_d;
            done_q       <= done_d;
            bist_rst_n_q <= bist_rst_n_d;
            bist_valid_q <= bist_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bist_rst_n   = bist_rst_n_q;
    assign bist_valid   = bist_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = verdict_q.pass;
    assign fail         = verdict_q.fail;
    assign timeout      = verdict_q.timeout;
    assign captured_sig = captured_q;
    assign state_dbg    = state_q;

endmodule
